// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives a trial operand into an external
// magnitude comparator and binary-searches MSB-first for the hidden target.
module sar_search_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cmp_aeb,
   input  logic             cmp_agb,
   input  logic             cmp_alb,
   output logic [WIDTH-1:0] guess,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             found,
   output logic             err,
   output logic [1:0]       state_dbg
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SEARCH = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] acc;
   logic [IW-1:0]    idx;

   logic [2:0]       flags;
   logic             one_hot;
   logic [WIDTH-1:0] bit_mask;
   logic [WIDTH-1:0] acc_upd;

   // Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse and
   // result/found/err are valid from that cycle until the next accepted start.
   always_comb begin
      flags    = {cmp_aeb, cmp_agb, cmp_alb};
      one_hot  = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
      bit_mask = ONE << idx;
      acc_upd  = cmp_alb ? (acc | bit_mask) : acc;
   end

   assign busy      = (state == SEARCH);
   assign done      = (state == DONE);
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         acc    <= '0;
         idx    <= IW'(WIDTH - 1);
         guess  <= '0;
         result <= '0;
         found  <= 1'b0;
         err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc   <= '0;
                  idx   <= IW'(WIDTH - 1);
                  found <= 1'b0;
                  err   <= 1'b0;
                  guess <= MSB;
                  state <= SEARCH;
               end
            end
            SEARCH: begin
               if (!one_hot) begin
                  // Comparator disagreed with itself: abort with the bits settled so far.
                  err    <= 1'b1;
                  found  <= 1'b0;
                  result <= acc;
                  guess  <= '0;
                  state  <= DONE;
               end else if (cmp_aeb) begin
                  result <= guess;
                  found  <= 1'b1;
                  guess  <= '0;
                  state  <= DONE;
               end else if (idx == '0) begin
                  acc    <= acc_upd;
                  result <= acc_upd;
                  found  <= 1'b0;
                  guess  <= '0;
                  state  <= DONE;
               end else begin
                  acc   <= acc_upd;
                  idx   <= idx - 1'b1;
                  guess <= acc_upd | (bit_mask >> 1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
